// File: rtl/lfsr_prbs_pkg.sv
// lfsr_prbs_pkg: checker state encoding and seed sizing shared with the generator-side controller
package lfsr_prbs_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEED    = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } prbs_state_t;
  function automatic int seed_words(input int lfsr_w, input int data_w);
    return (lfsr_w + data_w - 1) / data_w;
  endfunction
endpackage

// File: rtl/lfsr_prbs_check_lfsr.sv
// lfsr: combinational Fibonacci LFSR step over one data word (scrambler form, data_in=0 gives PRBS)
module lfsr #(
  parameter int                    LFSR_WIDTH  = 9,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 9'h021,
  parameter string                 LFSR_CONFIG = "FIBONACCI",
  parameter bit                    REVERSE     = 1'b0,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);
  if (LFSR_CONFIG != "FIBONACCI") begin : g_cfg
    $error("lfsr: only FIBONACCI is supported");
  end
  if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_style
    $error("lfsr: unknown STYLE");
  end
  logic [LFSR_WIDTH-1:0] s;
  logic fb;
  // bits leave MSB-first unless REVERSE; each output bit becomes the new state LSB
  always_comb begin
    s = state_in;
    fb = 1'b0;
    data_out = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb = s[LFSR_WIDTH-1] ^ (^(s[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1])) ^ data_in[REVERSE ? i : DATA_WIDTH-1-i];
      data_out[REVERSE ? i : DATA_WIDTH-1-i] = fb;
      s = {s[LFSR_WIDTH-2:0], fb};
    end
    state_out = s;
  end
endmodule

// File: rtl/lfsr_prbs_check.sv
// lfsr_prbs_check: self-synchronising PRBS checker with lock qualification and saturating error counters
module lfsr_prbs_check
  import lfsr_prbs_pkg::*;
#(
  parameter int                    LFSR_WIDTH    = 9,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 9'h021,
  parameter string                 LFSR_CONFIG   = "FIBONACCI",
  parameter bit                    REVERSE       = 1'b0,
  parameter int                    DATA_WIDTH    = 8,
  parameter string                 STYLE         = "AUTO",
  parameter int                    LOCK_COUNT    = 8,
  parameter int                    UNLOCK_ERRORS = 4,
  parameter int                    COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_valid,
  input  logic                   clear_count,
  output logic                   locked,
  output logic                   error,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] error_word_count,
  output logic [COUNT_WIDTH-1:0] error_bit_count
);
  localparam int SW  = seed_words(LFSR_WIDTH, DATA_WIDTH);
  localparam int HW  = LFSR_WIDTH > DATA_WIDTH ? LFSR_WIDTH - DATA_WIDTH : 1;
  localparam int SCW = $clog2(SW + 1);
  localparam int GW  = $clog2(LOCK_COUNT + 1);
  localparam int BW  = $clog2(UNLOCK_ERRORS + 1);
  localparam int PW  = $clog2(DATA_WIDTH + 1);
  if (LOCK_COUNT < 1 || UNLOCK_ERRORS < 1) begin : g_par
    $error("lfsr_prbs_check: LOCK_COUNT and UNLOCK_ERRORS must be at least 1");
  end
  function automatic logic [PW-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < DATA_WIDTH; i++) popcount = popcount + PW'(v[i]);
  endfunction
  prbs_state_t            state_q, state_d;
  logic [LFSR_WIDTH-1:0]  exp_q, exp_d, exp_next, seed_val;
  logic [HW-1:0]          hist_q, hist_d;
  logic [SCW-1:0]         seed_q, seed_d;
  logic [GW-1:0]          good_q, good_d;
  logic [BW-1:0]          bad_q, bad_d;
  logic                   err_q, err_d, mism;
  logic [COUNT_WIDTH-1:0] ewc_q, ewc_d, ebc_q, ebc_d, ewc_sat, ebc_sat;
  logic [COUNT_WIDTH:0]   ebc_sum;
  logic [DATA_WIDTH-1:0]  exp_word, rx_bits;
  logic [HW+DATA_WIDTH-1:0] rx_cat;
  lfsr #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .LFSR_POLY  (LFSR_POLY),
    .LFSR_CONFIG(LFSR_CONFIG),
    .REVERSE    (REVERSE),
    .DATA_WIDTH (DATA_WIDTH),
    .STYLE      (STYLE)
  ) u_lfsr (
    .data_in  ('0),
    .state_in (exp_q),
    .data_out (exp_word),
    .state_out(exp_next)
  );
  // received bits in emission order, newest at LSB, so the tail is exactly the generator state
  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) rx_bits[i] = data_in[REVERSE ? DATA_WIDTH-1-i : i];
    rx_cat = {hist_q, rx_bits};
    seed_val = rx_cat[LFSR_WIDTH-1:0];
    mism = data_in != exp_word;
    ebc_sum = {1'b0, ebc_q} + (COUNT_WIDTH+1)'(popcount(data_in ^ exp_word));
    ebc_sat = ebc_sum[COUNT_WIDTH] ? '1 : ebc_sum[COUNT_WIDTH-1:0];
    ewc_sat = &ewc_q ? ewc_q : ewc_q + COUNT_WIDTH'(1);
  end
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    hist_d = hist_q;
    seed_d = seed_q;
    good_d = good_q;
    bad_d = bad_q;
    err_d = 1'b0;
    ewc_d = ewc_q;
    ebc_d = ebc_q;
    if (!enable) state_d = IDLE;
    else if (state_q == IDLE) begin
      state_d = SEED;
      seed_d = '0;
    end else if (data_valid) begin
      if (state_q == SEED) begin
        hist_d = rx_cat[HW-1:0];
        seed_d = seed_q + SCW'(1);
        if (seed_q == SCW'(SW - 1)) begin
          seed_d = '0;
          if (|seed_val) begin
            exp_d = seed_val;
            good_d = '0;
            state_d = ACQUIRE;
          end
        end
      end else begin
        exp_d = exp_next;
        err_d = mism;
        if (state_q == ACQUIRE) begin
          good_d = mism ? '0 : good_q + GW'(1);
          bad_d = '0;
          state_d = mism ? SEED : (good_q == GW'(LOCK_COUNT - 1)) ? LOCKED : ACQUIRE;
        end else begin
          bad_d = mism ? bad_q + BW'(1) : '0;
          ewc_d = mism ? ewc_sat : ewc_q;
          ebc_d = mism ? ebc_sat : ebc_q;
          state_d = (mism && bad_q == BW'(UNLOCK_ERRORS - 1)) ? SEED : LOCKED;
        end
      end
    end
    if (clear_count) begin
      ewc_d = '0;
      ebc_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q <= '0;
      hist_q <= '0;
      seed_q <= '0;
      good_q <= '0;
      bad_q <= '0;
      err_q <= 1'b0;
      ewc_q <= '0;
      ebc_q <= '0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      hist_q <= hist_d;
      seed_q <= seed_d;
      good_q <= good_d;
      bad_q <= bad_d;
      err_q <= err_d;
      ewc_q <= ewc_d;
      ebc_q <= ebc_d;
    end
  end
  assign state = state_q;
  assign locked = state_q == LOCKED;
  assign error = err_q;
  assign error_word_count = ewc_q;
  assign error_bit_count = ebc_q;
endmodule

// File: tb/tb_lfsr_prbs_check.sv
// tb_lfsr_prbs_check: randomized scenarios against a bit-recurrence reference model of the checker
module tb_lfsr_prbs_check;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, data_valid = 1'b0, clear_count = 1'b0;
  logic [7:0] data_in = '0;
  logic locked, error;
  logic [1:0] state;
  logic [7:0] error_word_count, error_bit_count;
  logic [19:0] dut_vec;
  int total = 0, bad = 0;
  int gen_hist[$];
  int m_rx[$], m_exp[$];
  int m_state, m_seed, m_good, m_bad, m_err, m_ewc, m_ebc;

  lfsr_prbs_check #(.COUNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in), .data_valid(data_valid),
    .clear_count(clear_count), .locked(locked), .error(error), .state(state),
    .error_word_count(error_word_count), .error_bit_count(error_bit_count)
  );
  assign dut_vec = {state, locked, error, error_word_count, error_bit_count};
  always #5 clk = ~clk;

  // PRBS9 x^9+x^5+1 as a bit recurrence: b[n] = b[n-9] ^ b[n-5], MSB of each word sent first
  function automatic logic [7:0] gen_word();
    logic [7:0] w;
    int n, b;
    for (int i = 7; i >= 0; i--) begin
      n = gen_hist.size();
      b = gen_hist[n-9] ^ gen_hist[n-5];
      gen_hist.push_back(b);
      w[i] = b[0];
    end
    while (gen_hist.size() > 9) void'(gen_hist.pop_front());
    return w;
  endfunction

  function automatic logic [7:0] exp_word();
    logic [7:0] w;
    int n, b;
    for (int i = 7; i >= 0; i--) begin
      n = m_exp.size();
      b = m_exp[n-9] ^ m_exp[n-5];
      m_exp.push_back(b);
      w[i] = b[0];
    end
    while (m_exp.size() > 9) void'(m_exp.pop_front());
    return w;
  endfunction

  function automatic logic [19:0] model_vec();
    return {2'(m_state), m_state == 3, m_err != 0, 8'(m_ewc), 8'(m_ebc)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_seed = 0; m_good = 0; m_bad = 0; m_err = 0; m_ewc = 0; m_ebc = 0;
    m_rx.delete();
    m_exp.delete();
  endtask

  task automatic model_edge(input logic en, input logic v, input logic clr, input logic [7:0] d);
    int nz, nerr, n;
    logic [7:0] e;
    m_err = 0;
    if (!en) m_state = 0;
    else if (m_state == 0) begin
      m_state = 1; m_seed = 0; m_rx.delete();
    end else if (v) begin
      if (m_state == 1) begin
        for (int i = 7; i >= 0; i--) m_rx.push_back(int'(d[i]));
        m_seed++;
        if (m_seed == 2) begin
          m_seed = 0; nz = 0; n = m_rx.size();
          m_exp.delete();
          for (int i = n - 9; i < n; i++) begin
            m_exp.push_back(m_rx[i]);
            nz |= m_rx[i];
          end
          m_rx.delete();
          if (nz != 0) begin m_state = 2; m_good = 0; end
        end
      end else begin
        e = exp_word();
        nerr = $countones(d ^ e);
        m_err = nerr != 0;
        if (m_state == 2) begin
          if (nerr != 0) begin m_state = 1; m_good = 0; end
          else begin
            m_good++;
            if (m_good == 8) begin m_state = 3; m_bad = 0; end
          end
        end else if (nerr != 0) begin
          m_ewc = m_ewc + 1 > 255 ? 255 : m_ewc + 1;
          m_ebc = m_ebc + nerr > 255 ? 255 : m_ebc + nerr;
          m_bad++;
          if (m_bad == 4) m_state = 1;
        end else m_bad = 0;
      end
    end
    if (clr) begin m_ewc = 0; m_ebc = 0; end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic clr);
    data_valid = v; data_in = d; clear_count = clr;
    @(posedge clk);
    model_edge(enable, v, clr, d);
    #1;
  endtask

  task automatic run_to_lock(input string tag, input int limit, input int pvalid, output int cyc, output int vw);
    logic v;
    int pre;
    cyc = 0; vw = 0;
    while (!locked && cyc < limit) begin
      v = $urandom_range(0, 99) < pvalid;
      pre = m_state;
      step(v, v ? gen_word() : 8'($urandom), 1'b0);
      cyc++;
      if (v && pre != 0) vw++;
      total++;
      if (dut_vec !== model_vec()) begin bad++; $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, dut_vec, model_vec()); end
    end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL %s_timeout locked=%b want=1", tag, locked); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut_vec !== 20'h0) begin bad++; $display("FAIL reset got=%h want=%h", dut_vec, 20'h0); end
    model_reset();
    rst_n = 1'b1;
    step(1'b1, 8'h5a, 1'b0);
    total++;
    if (dut_vec !== model_vec()) begin bad++; $display("FAIL reset_idle got=%h want=%h", dut_vec, model_vec()); end
  endtask

  task automatic test_lock();
    int cyc, vw;
    enable = 1'b1;
    step(1'b1, gen_word(), 1'b0);
    total++;
    if (state !== 2'd1) begin bad++; $display("FAIL lock_seed_state got=%0d want=1", state); end
    step(1'b1, gen_word(), 1'b0);
    step(1'b1, gen_word(), 1'b0);
    total++;
    if (state !== 2'd2) begin bad++; $display("FAIL lock_acq_state got=%0d want=2", state); end
    run_to_lock("lock", 40, 100, cyc, vw);
    total++;
    if (cyc + 3 != 11) begin bad++; $display("FAIL lock_time got=%0d want=11", cyc + 3); end
    total++;
    if ({error_word_count, error_bit_count} !== 16'h0) begin bad++; $display("FAIL lock_counts got=%h want=0", {error_word_count, error_bit_count}); end
  endtask

  task automatic test_single_error();
    repeat (3) begin
      step(1'b1, gen_word(), 1'b0);
      total++;
      if (dut_vec !== model_vec()) begin bad++; $display("FAIL single_pre got=%h want=%h", dut_vec, model_vec()); end
    end
    step(1'b1, gen_word() ^ 8'h01, 1'b0);
    total++;
    if (dut_vec !== {2'd3, 1'b1, 1'b1, 8'd1, 8'd1}) begin bad++; $display("FAIL single_err got=%h want=%h", dut_vec, {2'd3, 1'b1, 1'b1, 8'd1, 8'd1}); end
    step(1'b1, gen_word(), 1'b0);
    total++;
    if (dut_vec !== {2'd3, 1'b1, 1'b0, 8'd1, 8'd1}) begin bad++; $display("FAIL single_after got=%h want=%h", dut_vec, {2'd3, 1'b1, 1'b0, 8'd1, 8'd1}); end
  endtask

  task automatic test_unlock_burst();
    int cyc, vw;
    step(1'b1, gen_word(), 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, gen_word() ^ 8'hff, 1'b0);
      total++;
      if (dut_vec !== model_vec()) begin bad++; $display("FAIL burst_%0d got=%h want=%h", i, dut_vec, model_vec()); end
    end
    total++;
    if ({state, error_word_count, error_bit_count} !== {2'd1, 8'd4, 8'd32}) begin
      bad++; $display("FAIL burst_end got=%h want=%h", {state, error_word_count, error_bit_count}, {2'd1, 8'd4, 8'd32});
    end
    run_to_lock("relock", 40, 100, cyc, vw);
    total++;
    if (cyc != 10) begin bad++; $display("FAIL relock_time got=%0d want=10", cyc); end
  endtask

  task automatic test_zero_seed();
    int cyc, vw;
    enable = 1'b0;
    step(1'b1, 8'h00, 1'b0);
    enable = 1'b1;
    step(1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 8'h00, 1'b0);
      total++;
      if (dut_vec !== {2'd1, 18'h0} || dut_vec !== model_vec()) begin bad++; $display("FAIL zero_seed i=%0d got=%h want=%h", i, dut_vec, {2'd1, 18'h0}); end
    end
    run_to_lock("zero_relock", 40, 100, cyc, vw);
  endtask

  task automatic test_saturation();
    logic [7:0] m;
    step(1'b1, gen_word(), 1'b1);
    for (int r = 0; r < 11; r++) begin
      m = r < 10 ? 8'hff : 8'h0f;
      for (int j = 0; j < 4; j++) begin
        step(1'b1, gen_word() ^ (j < 3 ? m : 8'h00), 1'b0);
        total++;
        if (dut_vec !== model_vec()) begin bad++; $display("FAIL sat_ramp r=%0d got=%h want=%h", r, dut_vec, model_vec()); end
      end
    end
    total++;
    if (error_bit_count !== 8'd252) begin bad++; $display("FAIL sat_preset got=%0d want=252", error_bit_count); end
    step(1'b1, gen_word() ^ 8'hff, 1'b0);
    total++;
    if (error_bit_count !== 8'hff) begin bad++; $display("FAIL sat_hit got=%0d want=255", error_bit_count); end
    step(1'b1, gen_word() ^ 8'hff, 1'b0);
    total++;
    if ({error_word_count, error_bit_count} !== {8'd35, 8'hff}) begin bad++; $display("FAIL sat_hold got=%h want=%h", {error_word_count, error_bit_count}, {8'd35, 8'hff}); end
    step(1'b1, gen_word(), 1'b0);
    step(1'b1, gen_word() ^ 8'hff, 1'b1);
    total++;
    if ({error, error_word_count, error_bit_count} !== {1'b1, 16'h0}) begin bad++; $display("FAIL clear_coincident got=%h want=%h", {error, error_word_count, error_bit_count}, {1'b1, 16'h0}); end
    step(1'b1, gen_word(), 1'b0);
    total++;
    if (dut_vec !== model_vec()) begin bad++; $display("FAIL sat_after got=%h want=%h", dut_vec, model_vec()); end
  endtask

  task automatic test_valid_toggle();
    int cyc, vw;
    enable = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    enable = 1'b1;
    run_to_lock("valid_toggle", 400, 50, cyc, vw);
    total++;
    if (vw != 10) begin bad++; $display("FAIL toggle_words got=%0d want=10", vw); end
  endtask

  task automatic test_random_errors();
    logic v, clr;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      v = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 49) == 0;
      d = v ? gen_word() ^ ($urandom_range(0, 5) == 0 ? 8'($urandom_range(1, 255)) : 8'h00) : 8'($urandom);
      step(v, d, clr);
      total++;
      if (dut_vec !== model_vec()) begin bad++; $display("FAIL random i=%0d got=%h want=%h", i, dut_vec, model_vec()); end
    end
  endtask

  task automatic test_async_reset();
    int cyc, vw;
    run_to_lock("pre_reset", 100, 100, cyc, vw);
    step(1'b1, gen_word() ^ 8'h03, 1'b0);
    total++;
    if (dut_vec !== model_vec()) begin bad++; $display("FAIL pre_reset_err got=%h want=%h", dut_vec, model_vec()); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec !== 20'h0) begin bad++; $display("FAIL async_reset got=%h want=%h", dut_vec, 20'h0); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_to_lock("post_reset", 40, 100, cyc, vw);
    total++;
    if (cyc != 11) begin bad++; $display("FAIL post_reset_time got=%0d want=11", cyc); end
  endtask

  initial begin
    repeat (9) gen_hist.push_back(1);
    model_reset();
    test_reset();
    test_lock();
    test_single_error();
    test_unlock_burst();
    test_zero_seed();
    test_saturation();
    test_valid_toggle();
    test_random_errors();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
